// File: rtl/ahb3lite_sram_slave_if.sv
// rtl/ahb3lite_sram_slave_if.sv - AHB3-Lite bus bundle between interconnect slave port and SRAM responder
// Clock and reset stay outside; the interconnect side drives the master modport.
interface ahb3lite_sram_slave_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite SRAM responder with programmable wait states
// Byte-lane writes, two-cycle ERROR response, pipelined accept with no bubble.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb3lite_sram_slave_if.slave bus
);
  localparam int NB    = HDATA_SIZE / 8;
  localparam int ALIGN = $clog2(NB);
  localparam int IW    = HADDR_SIZE - ALIGN;
  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [AW-1:0]         r_idx;
  logic [NB-1:0]         r_be;
  logic                  r_write;
  logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_take;
  logic                  w_err;
  logic [IW-1:0]         w_word;
  logic [ALIGN-1:0]      w_off;
  logic [7:0]            w_amask;
  logic [NB-1:0]         w_be;
  logic                  w_unused;

  assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_take   = w_accept & ((r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2));
  assign w_word   = bus.HADDR[HADDR_SIZE-1:ALIGN];
  assign w_off    = bus.HADDR[ALIGN-1:0];
  assign w_amask  = (8'd1 << bus.HSIZE) - 8'd1;
  assign w_err    = (w_word >= IW'(MEM_DEPTH))
                  | (bus.HSIZE > 3'(ALIGN))
                  | (|(w_amask[ALIGN-1:0] & w_off));
  assign w_unused = &{1'b0, bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0], w_amask};

  // Little-endian lane enables: lanes [off, off + 2**HSIZE)
  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++) begin
      w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << bus.HSIZE));
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_WAIT:  w_next = (r_cnt <= 3'd1) ? S_DATA : S_WAIT;
      S_ERR1:  w_next = S_ERR2;
      default: begin
        if (w_take) begin
          w_next = w_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_idx   <= w_word[AW-1:0];
        r_be    <= w_be;
        r_write <= bus.HWRITE & ~w_err;
        r_cnt   <= w_err ? 3'd0 : 3'(WAIT_STATES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Storage is deliberately not reset; a reset before the DATA edge drops the write.
  always_ff @(posedge HCLK) begin
    if ((r_state == S_DATA) && r_write) begin
      for (int b = 0; b < NB; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign bus.HRDATA    = (r_state == S_DATA) ? r_mem[r_idx] : '0;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - scoreboard bench for ahb3lite_sram_slave
// Three instances (WAIT_STATES 1, 0, 3) share one stimulus bus; act selects the live one.
module tb_ahb3lite_sram_slave;
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        b_hsel;
  logic [31:0] b_haddr;
  logic [31:0] b_hwdata;
  logic        b_hwrite;
  logic [2:0]  b_hsize;
  logic [1:0]  b_htrans;
  int          act;

  logic [2:0]       o_rdy;
  logic [2:0]       o_resp;
  logic [2:0][31:0] o_rdata;

  ahb3lite_sram_slave_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].HSEL      = b_hsel && (act == g);
    assign bus[g].HADDR     = b_haddr;
    assign bus[g].HWDATA    = b_hwdata;
    assign bus[g].HWRITE    = b_hwrite;
    assign bus[g].HSIZE     = b_hsize;
    assign bus[g].HBURST    = 3'd0;
    assign bus[g].HPROT     = 4'd0;
    assign bus[g].HTRANS    = b_htrans;
    assign bus[g].HMASTLOCK = 1'b0;
    assign bus[g].HREADY    = bus[g].HREADYOUT;
    assign o_rdy[g]         = bus[g].HREADYOUT;
    assign o_resp[g]        = bus[g].HRESP;
    assign o_rdata[g]       = bus[g].HRDATA;

    ahb3lite_sram_slave #(
      .HADDR_SIZE (32),
      .HDATA_SIZE (32),
      .MEM_DEPTH  (256),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .HCLK   (HCLK),
      .HRESETn(HRESETn),
      .bus    (bus[g])
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic        chk;
    logic [31:0] data;
    int          waits;
  } xfer_t;

  xfer_t pend [$];
  xfer_t sbq  [$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (inst %0d, t=%0t)", nm, got, want, act, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic tx(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d,
                    input logic e, input logic c, input logic [31:0] x);
    xfer_t t;
    t.addr = a; t.wr = w; t.size = s; t.wdata = d;
    t.err = e; t.chk = c; t.data = x; t.waits = 0;
    pend.push_back(t);
  endtask

  task automatic wait_ready();
    int n = 0;
    forever begin
      @(negedge HCLK);
      if (o_rdy[act]) break;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic run();
    xfer_t t;
    for (int i = 0; i < pend.size(); i++) begin
      t = pend[i];
      t.waits  = ws_of(act);
      b_hsel   = 1'b1;
      b_htrans = (i == 0) ? 2'b10 : 2'b11;
      b_haddr  = t.addr;
      b_hwrite = t.wr;
      b_hsize  = t.size;
      sbq.push_back(t);
      wait_ready();
      b_hwdata = t.wr ? t.wdata : 32'h0;
    end
    b_hsel = 1'b0; b_htrans = 2'b00; b_haddr = 32'h0; b_hwrite = 1'b0;
    wait_ready();
    repeat (2) @(posedge HCLK);
    #1;
    pend.delete();
  endtask

  // Monitor: tracks data phases from the bus and checks each completion against the scoreboard
  initial begin
    logic  in_dp;
    int    lows;
    logic  resp_any;
    xfer_t e;
    in_dp = 1'b0; lows = 0; resp_any = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        in_dp = 1'b0;
      end else begin
        if (in_dp) begin
          if (!o_rdy[act]) begin
            lows++;
            resp_any = resp_any | o_resp[act];
            chk("rdata_not_data", o_rdata[act], 32'h0);
          end else begin
            in_dp = 1'b0;
            if (sbq.size() == 0) begin
              chk("sb_underflow", 32'd1, 32'd0);
            end else begin
              e = sbq.pop_front();
              if (e.err) begin
                chk("err_low_cycles", 32'(lows), 32'd1);
                chk("err_resp_first", 32'(resp_any), 32'd1);
                chk("err_resp_second", 32'(o_resp[act]), 32'd1);
                chk("err_rdata", o_rdata[act], 32'h0);
              end else begin
                chk("ok_wait_cycles", 32'(lows), 32'(e.waits));
                chk("ok_resp", 32'({resp_any, o_resp[act]}), 32'd0);
                if (e.chk) chk("rdata", o_rdata[act], e.data);
              end
            end
          end
        end
        if (o_rdy[act] && b_hsel && b_htrans[1]) begin
          in_dp = 1'b1; lows = 0; resp_any = 1'b0;
        end
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    b_hsel = 1'b0; b_haddr = 32'h0; b_hwdata = 32'h0; b_hwrite = 1'b0;
    b_hsize = 3'd0; b_htrans = 2'b00; act = 0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    @(negedge HCLK);
    for (int k = 0; k < 3; k++) begin
      chk("rst_hreadyout", 32'(o_rdy[k]), 32'd1);
      chk("rst_hresp", 32'(o_resp[k]), 32'd0);
      chk("rst_hrdata", o_rdata[k], 32'h0);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge HCLK);
      chk("idle_outputs", {o_rdata[0][29:0], o_rdy[0], o_resp[0]}, 32'h2);
    end
    @(posedge HCLK); #1;

    act = 0;
    tx(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    tx(32'h10, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    run();

    tx(32'h20, 1'b1, 3'd2, 32'h00000000, 1'b0, 1'b0, 32'h0);
    tx(32'h22, 1'b1, 3'd0, 32'h11AA2233, 1'b0, 1'b0, 32'h0);
    tx(32'h20, 1'b1, 3'd1, 32'h55661234, 1'b0, 1'b0, 32'h0);
    tx(32'h20, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h00AA1234);
    run();

    tx(32'h00,  1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    tx(32'h400, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0);
    tx(32'h01,  1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    tx(32'h00,  1'b1, 3'd3, 32'h00000000, 1'b1, 1'b0, 32'h0);
    tx(32'h00,  1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
    run();

    act = 1;
    tx(32'h40, 1'b1, 3'd2, 32'h00000055, 1'b0, 1'b0, 32'h0);
    tx(32'h40, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h00000055);
    tx(32'h43, 1'b1, 3'd0, 32'h77000000, 1'b0, 1'b0, 32'h0);
    tx(32'h40, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h77000055);
    run();

    act = 2;
    tx(32'h80, 1'b1, 3'd2, 32'h11112222, 1'b0, 1'b0, 32'h0);
    tx(32'h80, 1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h11112222);
    run();

    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = 32'h80; b_hwrite = 1'b1; b_hsize = 3'd2;
    wait_ready();
    b_hwdata = 32'h99999999;
    b_hsel = 1'b0; b_htrans = 2'b00;
    @(posedge HCLK); #1;
    chk("in_second_wait", 32'(o_rdy[2]), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("midrst_hreadyout", 32'(o_rdy[2]), 32'd1);
    chk("midrst_hresp", 32'(o_resp[2]), 32'd0);
    chk("midrst_hrdata", o_rdata[2], 32'h0);
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    tx(32'h80, 1'b0, 3'd2, 32'h0, 1'b0, 1'b1, 32'h11112222);
    run();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
